// File: rtl/mcpu5_out_port.sv
// mcpu5_out_port: snoops the MCPU5 instruction stream and architectural state.
// It queues accumulator values written by OUT for a host to drain over a
// valid/ready handshake, detects the jump-to-self halt idiom, and counts
// retired instructions with a saturating counter.
module mcpu5_out_port #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       inst_in,
    input  logic [7:0]       accu_in,
    input  logic             carry_in,
    input  logic [7:0]       pc_in,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [5:0]  OP_OUT = 6'b111001;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t        state, state_nxt;
    logic [5:0]    park_inst;
    logic [7:0]    park_pc;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count;

    logic          push_req, pop, push, full, empty;
    logic          jump_taken, self_loop;
    logic [7:0]    jump_target;

    // Handshake decode and jump decode mirroring the core
    always_comb begin
        empty       = (count == '0);
        full        = (count == CW'(DEPTH));
        push_req    = (inst_in == OP_OUT);
        pop         = !empty && out_ready;
        push        = push_req && (!full || pop);
        rd_next     = rd_ptr + 1'b1;
        jump_taken  = (inst_in[5:4] == 2'b00) && !carry_in;
        jump_target = {pc_in[7:4], inst_in[3:0]};
        self_loop   = jump_taken && (jump_target == pc_in);
    end

    // Halt FSM next state: park on a taken jump-to-self, leave when the stream moves
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (self_loop) state_nxt = HALTED;
            end
            HALTED: begin
                if ((inst_in != park_inst) || (pc_in != park_pc)) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Halt FSM state register and parked instruction/PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            park_inst <= '0;
            park_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && self_loop) begin
                park_inst <= inst_in;
                park_pc   <= pc_in;
            end
        end
    end

    // FIFO storage; occupancy lives in count, so contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= accu_in;
    end

    // FIFO pointers, occupancy, registered head and sticky overflow.
    // The head register is loaded from storage on pop, or straight from
    // accu_in when the pushed entry becomes the new head, so it holds its
    // last value once the FIFO drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pop) begin
                if (count > CW'(1)) out_data <= mem[rd_next];
                else if (push)      out_data <= accu_in;
            end else if (empty && push) begin
                out_data <= accu_in;
            end
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // Retired-instruction counter: counts every RUN edge, saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (state == RUN && retired != '1) begin
            retired <= retired + 1'b1;
        end
    end

    assign out_valid = !empty;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_mcpu5_out_port.sv
// Directed bench for mcpu5_out_port: FIFO ordering, overflow, full/empty
// push-pop corners, halt detection, retired counting and async reset.
module tb_mcpu5_out_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  inst_in;
    logic [7:0]  accu_in;
    logic        carry_in;
    logic [7:0]  pc_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        halted;
    logic [15:0] retired;

    logic [7:0]  s_data;
    logic        s_valid, s_ovf, s_halted;
    logic [2:0]  s_retired;

    int checks = 0;
    int errors = 0;
    logic [15:0] r0;

    localparam logic [5:0] OUT  = 6'b111001;
    localparam logic [5:0] IDLE = 6'b010000;

    always #5 clk = ~clk;

    mcpu5_out_port #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .accu_in(accu_in),
        .carry_in(carry_in), .pc_in(pc_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .halted(halted), .retired(retired)
    );

    mcpu5_out_port #(.DEPTH(2), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .inst_in(inst_in), .accu_in(accu_in),
        .carry_in(carry_in), .pc_in(pc_in), .out_data(s_data),
        .out_valid(s_valid), .out_ready(out_ready), .overflow(s_ovf),
        .halted(s_halted), .retired(s_retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; inst_in = IDLE; accu_in = 8'h00; carry_in = 1'b0;
        pc_in = 8'h10; out_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        rst = 1'b1;

        // ten RUN edges: exact count, small counter saturates at 7
        repeat (10) tick();
        chk("retired_10", 32'(retired), 32'd10);
        chk("retired_sat", 32'(s_retired), 32'd7);

        // three OUTs, latency 1, then in-order drain
        inst_in = OUT; accu_in = 8'h05;
        chk("lat_before", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h05);
        accu_in = 8'hFA; tick();
        accu_in = 8'h33; tick();
        inst_in = IDLE; tick();
        chk("hold_head", 32'(out_data), 32'h05);
        out_ready = 1'b1;
        tick(); chk("pop_fa", 32'(out_data), 32'hFA);
        tick(); chk("pop_33", 32'(out_data), 32'h33);
        chk("pop_33_valid", 32'(out_valid), 32'd1);
        tick(); chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_hold", 32'(out_data), 32'h33);
        chk("no_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b0;

        // five OUTs into a depth-4 FIFO: last one dropped, overflow sticks
        inst_in = OUT;
        for (int i = 1; i <= 5; i++) begin
            accu_in = 8'(i);
            tick();
        end
        inst_in = IDLE;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        tick(); chk("ovf_d2", 32'(out_data), 32'h02);
        tick(); chk("ovf_d3", 32'(out_data), 32'h03);
        tick(); chk("ovf_d4", 32'(out_data), 32'h04);
        tick(); chk("ovf_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;

        // full FIFO with simultaneous push and pop
        pulse_reset();
        inst_in = OUT;
        for (int i = 0; i < 4; i++) begin
            accu_in = 8'h10 + 8'(i);
            tick();
        end
        accu_in = 8'hAA; out_ready = 1'b1;
        tick();
        inst_in = IDLE;
        chk("full_pp_head", 32'(out_data), 32'h11);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        tick(); chk("full_pp_12", 32'(out_data), 32'h12);
        tick(); chk("full_pp_13", 32'(out_data), 32'h13);
        tick(); chk("full_pp_aa", 32'(out_data), 32'hAA);
        tick(); chk("full_pp_empty", 32'(out_valid), 32'd0);

        // empty FIFO with push and ready: no fall-through
        inst_in = OUT; accu_in = 8'h77;
        tick();
        inst_in = IDLE;
        chk("empty_pp_valid", 32'(out_valid), 32'd1);
        chk("empty_pp_data", 32'(out_data), 32'h77);
        tick(); chk("empty_pp_pop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // jump-to-self halt and resume
        pc_in = 8'h27; inst_in = 6'b000111; carry_in = 1'b0;
        r0 = retired;
        tick();
        chk("halt_enter", 32'(halted), 32'd1);
        chk("halt_ret1", 32'(retired), 32'(r0 + 16'd1));
        tick(); tick();
        chk("halt_stay", 32'(halted), 32'd1);
        chk("halt_frozen", 32'(retired), 32'(r0 + 16'd1));
        inst_in = 6'b010001;
        tick();
        chk("halt_exit", 32'(halted), 32'd0);
        chk("exit_ret", 32'(retired), 32'(r0 + 16'd1));
        tick();
        chk("run_ret", 32'(retired), 32'(r0 + 16'd2));

        // self-jump with carry set is not taken; carry clear then halts
        inst_in = 6'b000111; carry_in = 1'b1;
        tick();
        chk("carry_nt", 32'(halted), 32'd0);
        carry_in = 1'b0;
        tick();
        chk("carry_clr_halt", 32'(halted), 32'd1);

        // async reset with two queued entries, overflow set and halted
        inst_in = OUT; pc_in = 8'h40;
        for (int i = 0; i < 5; i++) begin
            accu_in = 8'hC0 + 8'(i);
            tick();
        end
        out_ready = 1'b1; inst_in = IDLE;
        tick(); tick();
        out_ready = 1'b0;
        pc_in = 8'h27; inst_in = 6'b000111;
        tick();
        chk("pre_valid", 32'(out_valid), 32'd1);
        chk("pre_halted", 32'(halted), 32'd1);
        chk("pre_ovf", 32'(overflow), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'h00);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_retired", 32'(retired), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
